xorshift_gen: RTL and testbench



---
 rtl/xorshift_pkg.sv | 18 +
 rtl/xorshift_gen_if.sv | 28 ++
 rtl/xorshift32_step.sv | 15 +
 rtl/xorshift_gen.sv | 89 ++++++++
 tb/tb_xorshift_gen.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/xorshift_pkg.sv
// Shared constants and types for the xorshift32 producer stage.
//   XS_SH_A/B/C    : xorshift32 shift triple (13/17/5)
//   XS_NUM_OUT_DEF : default number of values generated per seed
//   xs_word_t      : 32-bit data word
//   xs_state_e     : generator FSM states
package xorshift_pkg;
  localparam int XS_SH_A        = 13;
  localparam int XS_SH_B        = 17;
  localparam int XS_SH_C        = 5;
  localparam int XS_NUM_OUT_DEF = 256;

  typedef logic [31:0] xs_word_t;

  typedef enum logic {
    IDLE = 1'b0,
    GEN  = 1'b1
  } xs_state_e;
endpackage

// File: rtl/xorshift_gen_if.sv
// Seed-in / FIFO-write bundle of the xorshift producer.
//   seed_valid, seed : seed pulse from the clk1->clk2 synchronizer
//   fifo_full        : downstream FIFO full flag (clk2 domain)
//   out_valid        : FIFO write enable
//   rand_num         : FIFO write data
//   busy, done       : run status
// Modports: master = generator side, slave = environment side.
interface xorshift_gen_if;
  import xorshift_pkg::*;

  logic     seed_valid;
  xs_word_t seed;
  logic     fifo_full;
  logic     out_valid;
  xs_word_t rand_num;
  logic     busy;
  logic     done;

  modport master (
    input  seed_valid, seed, fifo_full,
    output out_valid, rand_num, busy, done
  );

  modport slave (
    output seed_valid, seed, fifo_full,
    input  out_valid, rand_num, busy, done
  );
endinterface

// File: rtl/xorshift32_step.sv
// One xorshift32 step, purely combinational.
//   v : current state word
//   y : xs(v) = three xor-shift stages (<<13, >>17, <<5), logical, 32-bit
module xorshift32_step
  import xorshift_pkg::*;
(
  input  xs_word_t v,
  output xs_word_t y
);
  xs_word_t t1, t2;

  assign t1 = v  ^ (v  << XS_SH_A);
  assign t2 = t1 ^ (t1 >> XS_SH_B);
  assign y  = t2 ^ (t2 << XS_SH_C);
endmodule

// File: rtl/xorshift_gen.sv
// xorshift32 producer: takes a seed, emits NUM_OUT consecutive xorshift32
// values into the downstream FIFO, stalling while the FIFO is full.
//   clk2, rst_n : stage clock, async active-low reset
//   bus         : seed input, FIFO write port and busy/done status
//   stall_cnt   : saturating count of full-stalled GEN cycles, present only
//                 when XORSHIFT_STALL_CNT_EN is defined
module xorshift_gen
  import xorshift_pkg::*;
#(
  parameter int NUM_OUT = XS_NUM_OUT_DEF,
  parameter int WIDTH   = 32
) (
  input  logic         clk2,
  input  logic         rst_n,
  xorshift_gen_if.master bus
`ifdef XORSHIFT_STALL_CNT_EN
  ,
  output logic [15:0]  stall_cnt
`endif
);
  localparam int CW = $clog2(NUM_OUT + 1);

  xs_state_e        state;
  logic [WIDTH-1:0] x_r;
  logic [CW-1:0]    cnt;
  logic             done_r;
  xs_word_t         step_in, step_out;
  logic             wr;

  // One step instance serves both paths: in IDLE it scrambles the incoming
  // seed, in GEN it advances the running state.
  assign step_in = (state == IDLE) ? bus.seed : x_r;

  xorshift32_step u_step (
    .v (step_in),
    .y (step_out)
  );

  // Write enable is combinational on fifo_full so no write lands on a full FIFO.
  assign wr            = (state == GEN) && !bus.fifo_full;
  assign bus.out_valid = wr;
  assign bus.rand_num  = x_r;
  assign bus.busy      = (state == GEN);
  assign bus.done      = done_r;

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      x_r    <= '0;
      cnt    <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.seed_valid) begin
            x_r   <= step_out;
            cnt   <= '0;
            state <= GEN;
          end
        end
        GEN: begin
          // seed_valid is deliberately not looked at here: mid-run seeds drop.
          if (wr) begin
            x_r <= step_out;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(NUM_OUT - 1)) begin
              state  <= IDLE;
              done_r <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef XORSHIFT_STALL_CNT_EN
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state == IDLE) begin
      if (bus.seed_valid) stall_cnt <= '0;
    end else if (bus.fifo_full && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_xorshift_gen.sv
// Self-checking bench for xorshift_gen: expected words are pushed to a
// queue when a seed is sent and popped as the DUT writes them.
// Stall-counter test is built only with XORSHIFT_STALL_CNT_EN.
module tb_xorshift_gen;
  import xorshift_pkg::*;

  localparam int N = 256;

  logic clk2 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk2 = ~clk2;

  xorshift_gen_if bus ();
`ifdef XORSHIFT_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  xorshift_gen #(.NUM_OUT(N), .WIDTH(32)) dut (
    .clk2      (clk2),
    .rst_n     (rst_n),
    .bus       (bus)
`ifdef XORSHIFT_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int       errors = 0;
  int       checks = 0;
  xs_word_t q[$];
  bit       ov, dn, bz;
  xs_word_t rn;

  function automatic xs_word_t xs_m(input xs_word_t v);
    xs_word_t a;
    a = v ^ (v << 13);
    a = a ^ (a >> 17);
    a = a ^ (a << 5);
    return a;
  endfunction

  task automatic load(input xs_word_t s);
    xs_word_t v;
    v = xs_m(s);
    for (int i = 0; i < N; i++) begin
      q.push_back(v);
      v = xs_m(v);
    end
  endtask

  // Drive one cycle at the falling edge, then sample outputs 1 ns later.
  task automatic step(input bit full, input bit sv, input xs_word_t s);
    @(negedge clk2);
    bus.fifo_full  = full;
    bus.seed_valid = sv;
    bus.seed       = s;
    #1;
    ov = bus.out_valid;
    dn = bus.done;
    bz = bus.busy;
    rn = bus.rand_num;
  endtask

  task automatic test_reset();
    bus.fifo_full = 0; bus.seed_valid = 0; bus.seed = '0;
    rst_n = 0;
    step(0, 1, 32'h1234_5678);
    step(0, 0, 0);
    checks++; if (ov !== 0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", ov); end
    checks++; if (rn !== 0) begin errors++; $display("FAIL reset_rand_num got=%h exp=0", rn); end
    checks++; if (bz !== 0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", bz); end
    checks++; if (dn !== 0) begin errors++; $display("FAIL reset_done got=%0b exp=0", dn); end
    rst_n = 1;
    step(0, 0, 0);
    checks++; if (bz !== 0) begin errors++; $display("FAIL idle_after_reset_busy got=%0b exp=0", bz); end
  endtask

  task automatic test_seed_one();
    int w = 0; bit fin = 0; int bad = 0;
    load(32'h1);
    step(0, 1, 32'h1);
    checks++; if (ov !== 0) begin errors++; $display("FAIL seed1_idle_out_valid got=%0b exp=0", ov); end
    for (int c = 0; c < 400 && !fin; c++) begin
      step(0, 0, 0);
      if (ov) begin
        if (w == 0) begin
          checks++; if (rn !== 32'h0004_2021) begin errors++; $display("FAIL seed1_first got=%h exp=00042021", rn); end
        end
        if (q.size() == 0) bad++;
        else if (rn !== q.pop_front()) bad++;
        w++;
      end
      if (dn) begin
        fin = 1;
        checks++; if (bz !== 0) begin errors++; $display("FAIL seed1_busy_at_done got=%0b exp=0", bz); end
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL seed1_sequence bad_words=%0d exp=0", bad); end
    checks++; if (!fin) begin errors++; $display("FAIL seed1_done_timeout got=0 exp=1"); end
    checks++; if (w != N) begin errors++; $display("FAIL seed1_writes got=%0d exp=%0d", w, N); end
    step(0, 0, 0);
    checks++; if (dn !== 0) begin errors++; $display("FAIL seed1_done_width got=%0b exp=0", dn); end
    q.delete();
  endtask

  task automatic test_seed_zero();
    int w = 0; bit fin = 0; int bad = 0;
    step(0, 1, 32'h0);
    for (int c = 0; c < 400 && !fin; c++) begin
      step(0, 0, 0);
      if (ov) begin
        if (rn !== 32'h0) bad++;
        w++;
      end
      if (dn) fin = 1;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL zero_values nonzero=%0d exp=0", bad); end
    checks++; if (!fin || w != N) begin errors++; $display("FAIL zero_run writes=%0d done=%0b exp=%0d/1", w, fin, N); end
  endtask

  task automatic test_backpressure();
    int w = 0; bit fin = 0; int bad = 0; int viol = 0; int nfull = 0;
    bit f; xs_word_t s;
    s = $urandom();
    load(s);
    step(0, 1, s);
    for (int c = 0; c < 3000 && !fin; c++) begin
      f = $urandom_range(0, 1);
      step(f, 0, 0);
      if (f) nfull++;
      if (f && ov) viol++;
      if (ov) begin
        if (q.size() == 0) bad++;
        else if (rn !== q.pop_front()) bad++;
        w++;
      end
      if (dn) fin = 1;
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL bp_write_while_full got=%0d exp=0", viol); end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_sequence bad_words=%0d exp=0", bad); end
    checks++; if (!fin || w != N) begin errors++; $display("FAIL bp_run writes=%0d done=%0b exp=%0d/1", w, fin, N); end
    checks++; if (nfull == 0) begin errors++; $display("FAIL bp_no_stall_cycles got=0 exp>0"); end
    q.delete();
  endtask

  task automatic test_ignore_seed();
    int w = 0; bit fin = 0; int bad = 0; bit sv;
    xs_word_t a = 32'h1357_9BDF;
    load(a);
    step(0, 1, a);
    for (int c = 0; c < 400 && !fin; c++) begin
      // Stray seeds mid-run and coincident with the final write.
      sv = (w == 50) || (w == N - 1);
      step(0, sv, 32'hDEAD_BEEF);
      if (ov) begin
        if (q.size() == 0) bad++;
        else if (rn !== q.pop_front()) bad++;
        w++;
      end
      if (dn) fin = 1;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ignore_sequence bad_words=%0d exp=0", bad); end
    checks++; if (!fin || w != N) begin errors++; $display("FAIL ignore_run writes=%0d done=%0b exp=%0d/1", w, fin, N); end
    step(0, 0, 0);
    checks++; if (bz !== 0 || ov !== 0) begin errors++; $display("FAIL ignore_dropped busy=%0b out_valid=%0b exp=0/0", bz, ov); end
    q.delete();
  endtask

  task automatic test_reset_midrun();
    int w = 0; bit fin = 0; int bad = 0;
    xs_word_t s1 = 32'hCAFE_0001, s2 = 32'h0BAD_F00D;
    step(0, 1, s1);
    for (int c = 0; c < 200 && w < 100; c++) begin
      step(0, 0, 0);
      if (ov) w++;
    end
    @(negedge clk2);
    rst_n = 0;
    #1;
    checks++;
    if (bus.out_valid !== 0 || bus.rand_num !== 0 || bus.busy !== 0 || bus.done !== 0) begin
      errors++;
      $display("FAIL midrun_reset_outputs ov=%0b rn=%h busy=%0b done=%0b exp=0", bus.out_valid, bus.rand_num, bus.busy, bus.done);
    end
    step(0, 0, 0);
    checks++; if (ov !== 0 || rn !== 0 || bz !== 0) begin errors++; $display("FAIL midrun_reset_hold ov=%0b rn=%h busy=%0b exp=0", ov, rn, bz); end
    rst_n = 1;
    q.delete();
    w = 0;
    load(s2);
    step(0, 1, s2);
    for (int c = 0; c < 400 && !fin; c++) begin
      step(0, 0, 0);
      if (ov) begin
        if (q.size() == 0) bad++;
        else if (rn !== q.pop_front()) bad++;
        w++;
      end
      if (dn) fin = 1;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL midrun_new_sequence bad_words=%0d exp=0", bad); end
    checks++; if (!fin || w != N) begin errors++; $display("FAIL midrun_new_run writes=%0d done=%0b exp=%0d/1", w, fin, N); end
    q.delete();
  endtask

  task automatic test_back_to_back();
    int w = 0; int runs = 0; int bad = 0;
    xs_word_t s[2] = '{32'h2468_ACE0, 32'h8000_0001};
    load(s[0]);
    step(0, 1, s[0]);
    for (int c = 0; c < 800 && runs < 2; c++) begin
      step(0, 0, 0);
      if (ov) begin
        if (q.size() == 0) bad++;
        else if (rn !== q.pop_front()) bad++;
        w++;
      end
      if (dn) begin
        runs++;
        if (runs == 1) begin
          load(s[1]);
          step(0, 1, s[1]);
        end
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_sequence bad_words=%0d exp=0", bad); end
    checks++; if (runs != 2 || w != 2 * N) begin errors++; $display("FAIL b2b_runs runs=%0d writes=%0d exp=2/%0d", runs, w, 2 * N); end
    q.delete();
  endtask

`ifdef XORSHIFT_STALL_CNT_EN
  task automatic test_stall_cnt();
    int w = 0; bit fin = 0; int viol = 0; logic [15:0] at_done = '0;
    step(0, 1, 32'h7777_1111);
    for (int c = 0; c < 40; c++) begin
      step(1, 0, 0);
      if (ov) viol++;
    end
    for (int c = 0; c < 400 && !fin; c++) begin
      step(0, 0, 0);
      if (ov) w++;
      if (dn) begin fin = 1; at_done = stall_cnt; end
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL stall_write_while_full got=%0d exp=0", viol); end
    checks++; if (!fin || at_done !== 16'd40) begin errors++; $display("FAIL stall_cnt_at_done got=%0d exp=40", at_done); end
    step(0, 1, 32'h1);
    step(0, 0, 0);
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stall_cnt_clear got=%0d exp=0", stall_cnt); end
    fin = 0;
    for (int c = 0; c < 400 && !fin; c++) begin
      step(0, 0, 0);
      if (dn) fin = 1;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_seed_one();
    test_seed_zero();
    test_backpressure();
    test_ignore_seed();
    test_reset_midrun();
    test_back_to_back();
`ifdef XORSHIFT_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
